// File: rtl/instr_feeder_if.sv
// instr_feeder_if: host FIFO port plus cpu instruction/handshake signals.
// master = host/cpu side, slave = the feeder.
interface instr_feeder_if;
    logic        push;
    logic [15:0] push_data;
    logic        full;
    logic        empty;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic        busy;
    logic [7:0]  issued;
    logic        err;
    modport master (output push, push_data, w, input full, empty, in, load, s, busy, issued, err);
    modport slave (input push, push_data, w, output full, empty, in, load, s, busy, issued, err);
endinterface

// File: rtl/instr_feeder.sv
// instr_feeder: 8-deep instruction FIFO that feeds a cpu through a load/start/wait handshake.
// Optional watchdog on the wait phase when INSTR_FEEDER_WATCHDOG_EN is defined.
module instr_feeder (
    input logic clk,
    input logic reset,
    instr_feeder_if.slave f
);
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_LO, WAIT_HI} state_t;
    state_t state;
    logic [15:0] mem [8];
    logic [2:0] wp, rp;
    logic [3:0] cnt;
    logic push_ok, done, to, pop;
    assign f.full = cnt[3];
    assign f.empty = cnt == 4'd0;
    assign push_ok = f.push && !f.full;
    assign done = state == WAIT_HI && f.w;
    assign pop = done || to;
    always_ff @(posedge clk)
        if (push_ok) mem[wp] <= f.push_data;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (push_ok) wp <= wp + 3'd1;
            if (pop) rp <= rp + 3'd1;
            cnt <= cnt + 4'(push_ok) - 4'(pop);
        end
    // Head stays in the FIFO until completion; pushes during flight land behind it.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            f.in <= '0;
            f.load <= 1'b0;
            f.s <= 1'b0;
            f.busy <= 1'b0;
            f.issued <= '0;
        end else begin
            case (state)
                IDLE: if (!f.empty && f.w) begin
                    state <= LOAD;
                    f.load <= 1'b1;
                    f.busy <= 1'b1;
                    f.in <= mem[rp];
                end
                LOAD: begin
                    state <= START;
                    f.load <= 1'b0;
                    f.s <= 1'b1;
                end
                START: begin
                    state <= WAIT_LO;
                    f.s <= 1'b0;
                end
                WAIT_LO: if (!f.w) state <= WAIT_HI;
                WAIT_HI: state <= WAIT_HI;
                default: state <= IDLE;
            endcase
            if (pop) begin
                state <= IDLE;
                f.in <= '0;
                f.busy <= 1'b0;
            end
            if (done) f.issued <= f.issued + 8'd1;
        end
`ifdef INSTR_FEEDER_WATCHDOG_EN
    logic [7:0] wd;
    logic waiting;
    assign waiting = state == WAIT_LO || state == WAIT_HI;
    assign to = waiting && wd == 8'hFF && !done;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wd <= '0;
            f.err <= 1'b0;
        end else begin
            wd <= waiting && !pop ? wd + 8'd1 : 8'd0;
            if (to) f.err <= 1'b1;
        end
`else
    assign to = 1'b0;
    assign f.err = 1'b0;
`endif
endmodule

// File: doc/instr_feeder.md
INSTR_FEEDER -- requirements
Module: instr_feeder

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 push  input  1  host writes push_data into instruction FIFO this cycle.
REQ-004 push_data  input  16  encoded CPU instruction.
REQ-005 full  output  1  FIFO holds 8 entries; push ignored.
REQ-006 empty  output  1  FIFO holds 0 entries.
REQ-007 in  output  16  instruction word to the downstream cpu "in" port.
REQ-008 load  output  1  instruction-register load strobe to the cpu.
REQ-009 s  output  1  start strobe to the cpu.
REQ-010 w  input  1  cpu wait/idle flag; high = cpu idle.
REQ-011 busy  output  1  an instruction is in flight (state not IDLE).
REQ-012 issued  output  8  count of completed instructions.
REQ-013 err  output  1  sticky watchdog error flag (see Configuration).

Function
REQ-014 FIFO: 8 entries x 16 bits, circular read/write pointers, 4-bit occupancy count.
REQ-015 Push accepted when push=1 and full=0 at the clock edge; push while full is dropped with no state change.
REQ-016 full is evaluated before any same-cycle pop; push and pop in one cycle while not full leaves occupancy unchanged.
REQ-017 FSM states: IDLE, LOAD, START, WAIT_LO, WAIT_HI.
REQ-018 IDLE: if empty=0 and w=1 -> LOAD; otherwise remain.
REQ-019 LOAD: load=1 for exactly one cycle, in = FIFO head; -> START.
REQ-020 START: s=1 for exactly one cycle, load=0, in = head; -> WAIT_LO.
REQ-021 WAIT_LO: wait for w=0 (cpu acknowledged start); -> WAIT_HI.
REQ-022 WAIT_HI: wait for w=1; on that edge pop FIFO head, issued increments, -> IDLE.
REQ-023 A w that stays high through WAIT_LO never completes the instruction; only a low-to-high sequence does.
REQ-024 in holds the head value from LOAD through WAIT_HI; in = 16'h0000 in IDLE.
REQ-025 load and s are never high in the same cycle; each is registered (glitch-free).
REQ-026 Minimum per-instruction cost: 4 cycles plus cpu execution time; back-to-back instructions separated by one IDLE cycle.
REQ-027 issued wraps 255 -> 0 without error.
REQ-028 Head entry is not popped until completion; pushes during flight append behind it.

Reset
REQ-029 reset asserted, at any time including mid-instruction, forces IDLE, empties FIFO, pointers = 0.
REQ-030 Reset values: in=0, load=0, s=0, busy=0, full=0, empty=1, issued=0, err=0.
REQ-031 After reset deasserts, first LOAD occurs no earlier than the second rising edge.

Configuration
REQ-032 Macro INSTR_FEEDER_WATCHDOG_EN enables a 8-bit watchdog counting cycles spent in WAIT_LO plus WAIT_HI.
REQ-033 With macro: counter reaching 255 sets err=1 (sticky until reset), discards head entry, returns to IDLE, issued unchanged.
REQ-034 Without macro: no watchdog logic; err tied to 0; feeder waits on w indefinitely.

Verification
REQ-035 Reset, push 16'hD007 (MOV R0,#7), cpu model drops w after s, raises it 5 cycles later -> load then s one cycle each, in=16'hD007, issued=1, empty=1.
REQ-036 Push D007, D11F, A148, A83F, B268 back-to-back -> issued in push order, issued=5, one IDLE cycle between each.
REQ-037 Push 9 entries with no issue (w held 0 at start) -> full=1 after 8, ninth dropped, empty=1 only after 8 completions.
REQ-038 Assert reset during WAIT_HI with 3 queued -> immediately busy=0, empty=1, load=s=0, issued=0.
REQ-039 w held high after s (cpu never acknowledges) -> stays in WAIT_LO; with INSTR_FEEDER_WATCHDOG_EN err=1 after 255 cycles and head dropped; without it err=0 forever.
REQ-040 Issue 256 instructions -> issued returns to 0, err=0.
